// File: rtl/bus_arbiter2_if.sv
// Shared-port bundle between two requesters and bus_arbiter2.
// master = requester side, slave = arbiter side.
interface bus_arbiter2_if #(
  parameter int N = 16
);
  logic         req0;
  logic         req1;
  logic [N-1:0] d0;
  logic [N-1:0] d1;
  logic         gnt0;
  logic         gnt1;
  logic         sel;
  logic [N-1:0] out;
  logic         out_valid;

  modport master (
    output req0, req1, d0, d1,
    input  gnt0, gnt1, sel, out, out_valid
  );

  modport slave (
    input  req0, req1, d0, d1,
    output gnt0, gnt1, sel, out, out_valid
  );
endinterface

// File: rtl/bus_arbiter2.sv
// Two-requester round-robin arbiter with bounded tenure,
// driving the select of a shared 2:1 datapath mux.
module mux2 #(
  parameter int N = 16
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_sel,
  output logic [N-1:0] o_y
);
  assign o_y = i_sel ? i_b : i_a;
endmodule

module bus_arbiter2 #(
  parameter int N        = 16,
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  bus_arbiter2_if.slave  bus
);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT0,
    GRANT1
  } state_t;

  state_t        r_state;
  logic          r_last;
  logic [HW-1:0] r_hold;
  logic          r_gnt0;
  logic          r_gnt1;
  logic          r_sel;

  logic          w_pick0;
  logic          w_pick1;
  logic          w_sat;
  logic [N-1:0]  w_out;

  // Tie goes to whoever did not own the port last.
  assign w_pick0 = bus.req0 & (~bus.req1 | r_last);
  assign w_pick1 = bus.req1 & (~bus.req0 | ~r_last);
  assign w_sat   = (r_hold == HMAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_hold  <= '0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_sel   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          unique case (1'b1)
            w_pick0: begin
              r_state <= GRANT0;
              r_last  <= 1'b0;
              r_hold  <= '0;
              r_gnt0  <= 1'b1;
              r_sel   <= 1'b0;
            end
            w_pick1: begin
              r_state <= GRANT1;
              r_last  <= 1'b1;
              r_hold  <= '0;
              r_gnt1  <= 1'b1;
              r_sel   <= 1'b1;
            end
            default: ;
          endcase
        end
        GRANT0: begin
          if (bus.req1 && (!bus.req0 || w_sat)) begin
            r_state <= GRANT1;
            r_last  <= 1'b1;
            r_hold  <= '0;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b1;
            r_sel   <= 1'b1;
          end else if (!bus.req0) begin
            r_state <= IDLE;
            r_gnt0  <= 1'b0;
          end else if (!w_sat) begin
            r_hold  <= r_hold + 1'b1;
          end
        end
        GRANT1: begin
          if (bus.req0 && (!bus.req1 || w_sat)) begin
            r_state <= GRANT0;
            r_last  <= 1'b0;
            r_hold  <= '0;
            r_gnt1  <= 1'b0;
            r_gnt0  <= 1'b1;
            r_sel   <= 1'b0;
          end else if (!bus.req1) begin
            r_state <= IDLE;
            r_gnt1  <= 1'b0;
          end else if (!w_sat) begin
            r_hold  <= r_hold + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
        end
      endcase
    end
  end

  mux2 #(.N(N)) u_mux (
    .i_a   (bus.d0),
    .i_b   (bus.d1),
    .i_sel (r_sel),
    .o_y   (w_out)
  );

  assign bus.gnt0      = r_gnt0;
  assign bus.gnt1      = r_gnt1;
  assign bus.sel       = r_sel;
  assign bus.out       = w_out;
  assign bus.out_valid = r_gnt0 | r_gnt1;
endmodule

// File: tb/tb_bus_arbiter2.sv
// Directed bench for bus_arbiter2: vector table plus
// multi-cycle sequences (tenure, reset, MAX_HOLD=1).
module tb_bus_arbiter2;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  bus_arbiter2_if #(.N(16)) bus  ();
  bus_arbiter2_if #(.N(16)) bus1 ();

  bus_arbiter2 #(.N(16), .MAX_HOLD(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  bus_arbiter2 #(.N(16), .MAX_HOLD(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        req0;
    logic        req1;
    logic [15:0] d0;
    logic [15:0] d1;
    logic        g0;
    logic        g1;
    logic        sel;
    logic        ov;
    logic [15:0] out;
  } vec_t;

  vec_t tbl [17];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.req0 = 0; bus.req1 = 0;
    bus.d0   = 0; bus.d1   = 0;
    bus1.req0 = 0; bus1.req1 = 0;
    bus1.d0  = 16'hAAAA; bus1.d1 = 16'h5555;

    //         rst r0 r1 d0        d1        g0 g1 sel ov out
    tbl[0]  = '{0, 0, 0, 16'h1111, 16'hBEEF, 0, 0, 0, 0, 16'h1111};
    tbl[1]  = '{0, 0, 0, 16'h1111, 16'hBEEF, 0, 0, 0, 0, 16'h1111};
    tbl[2]  = '{1, 0, 0, 16'h1111, 16'hBEEF, 0, 0, 0, 0, 16'h1111};
    tbl[3]  = '{1, 0, 0, 16'h1111, 16'hBEEF, 0, 0, 0, 0, 16'h1111};
    tbl[4]  = '{1, 0, 1, 16'h1111, 16'hBEEF, 0, 1, 1, 1, 16'hBEEF};
    tbl[5]  = '{1, 0, 1, 16'h1111, 16'hBEEF, 0, 1, 1, 1, 16'hBEEF};
    tbl[6]  = '{1, 0, 0, 16'h1111, 16'hBEEF, 0, 0, 1, 0, 16'hBEEF};
    tbl[7]  = '{1, 1, 0, 16'h1234, 16'hBEEF, 1, 0, 0, 1, 16'h1234};
    tbl[8]  = '{1, 1, 1, 16'h1234, 16'hBEEF, 1, 0, 0, 1, 16'h1234};
    tbl[9]  = '{1, 0, 1, 16'h1234, 16'hBEEF, 0, 1, 1, 1, 16'hBEEF};
    tbl[10] = '{1, 0, 1, 16'h1234, 16'hBEEF, 0, 1, 1, 1, 16'hBEEF};
    tbl[11] = '{1, 1, 1, 16'h1234, 16'hBEEF, 0, 1, 1, 1, 16'hBEEF};
    tbl[12] = '{1, 1, 0, 16'h1234, 16'hBEEF, 1, 0, 0, 1, 16'h1234};
    tbl[13] = '{1, 0, 0, 16'h1234, 16'hBEEF, 0, 0, 0, 0, 16'h1234};
    tbl[14] = '{1, 1, 1, 16'h1234, 16'hBEEF, 0, 1, 1, 1, 16'hBEEF};
    tbl[15] = '{1, 0, 0, 16'h1234, 16'hBEEF, 0, 0, 1, 0, 16'hBEEF};
    tbl[16] = '{0, 0, 0, 16'h1234, 16'hBEEF, 0, 0, 0, 0, 16'h1234};

    for (int i = 0; i < 17; i++) begin
      rst_n    = tbl[i].rst_n;
      bus.req0 = tbl[i].req0;
      bus.req1 = tbl[i].req1;
      bus.d0   = tbl[i].d0;
      bus.d1   = tbl[i].d1;
      tick();
      chk($sformatf("v%0d gnt0", i), 16'(bus.gnt0), 16'(tbl[i].g0));
      chk($sformatf("v%0d gnt1", i), 16'(bus.gnt1), 16'(tbl[i].g1));
      chk($sformatf("v%0d sel", i), 16'(bus.sel), 16'(tbl[i].sel));
      chk($sformatf("v%0d oval", i), 16'(bus.out_valid),
          16'(tbl[i].ov));
      chk($sformatf("v%0d out", i), bus.out, tbl[i].out);
    end

    // single requester held 20 cycles: no preemption
    rst_n = 1; bus.req0 = 0; bus.req1 = 1;
    bus.d0 = 16'h0000; bus.d1 = 16'hBEEF;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("solo c%0d gnt1", k), 16'(bus.gnt1), 16'd1);
      chk($sformatf("solo c%0d out", k), bus.out, 16'hBEEF);
    end
    bus.req1 = 0;
    tick();
    chk("solo drop gnt1", 16'(bus.gnt1), 16'd0);
    chk("solo drop oval", 16'(bus.out_valid), 16'd0);

    // tie out of reset: 8 cycles each, alternating
    rst_n = 0;
    tick();
    rst_n = 1; bus.req0 = 1; bus.req1 = 1;
    for (int k = 1; k <= 24; k++) begin
      logic e0;
      tick();
      e0 = (((k - 1) / 8) % 2) == 0;
      chk($sformatf("tie c%0d gnt0", k), 16'(bus.gnt0), 16'(e0));
      chk($sformatf("tie c%0d gnt1", k), 16'(bus.gnt1), 16'(!e0));
      chk($sformatf("tie c%0d both", k),
          16'(bus.gnt0 & bus.gnt1), 16'd0);
    end

    // reset mid-grant
    rst_n = 0;
    tick();
    rst_n = 1; bus.req0 = 0; bus.req1 = 1;
    for (int k = 1; k <= 5; k++) tick();
    chk("mid gnt1 c5", 16'(bus.gnt1), 16'd1);
    rst_n = 0;
    tick();
    chk("mid rst gnt0", 16'(bus.gnt0), 16'd0);
    chk("mid rst gnt1", 16'(bus.gnt1), 16'd0);
    chk("mid rst sel", 16'(bus.sel), 16'd0);
    chk("mid rst oval", 16'(bus.out_valid), 16'd0);
    rst_n = 1; bus.req0 = 1; bus.req1 = 1;
    tick();
    chk("mid tie gnt0", 16'(bus.gnt0), 16'd1);
    chk("mid tie gnt1", 16'(bus.gnt1), 16'd0);

    // MAX_HOLD=1: strict alternation
    bus.req0 = 0; bus.req1 = 0;
    rst_n = 0;
    tick();
    rst_n = 1; bus1.req0 = 1; bus1.req1 = 1;
    for (int k = 1; k <= 6; k++) begin
      logic e0;
      tick();
      e0 = (k % 2) == 1;
      chk($sformatf("mh1 c%0d gnt0", k), 16'(bus1.gnt0), 16'(e0));
      chk($sformatf("mh1 c%0d gnt1", k), 16'(bus1.gnt1), 16'(!e0));
      chk($sformatf("mh1 c%0d sel", k), 16'(bus1.sel), 16'(!e0));
      chk($sformatf("mh1 c%0d out", k), bus1.out,
          e0 ? 16'hAAAA : 16'h5555);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bus_arbiter2.md
# bus_arbiter2

Two-requester, round-robin arbiter that shares one N-bit datapath resource (a 2:1 select feeding a shared bus or memory port) between requester 0 and requester 1. It owns the select line of the shared `mux2`, issues registered grants, and bounds each owner's tenure with a hold counter so neither side can starve the other. It sits between the two datapath sources (for example, instruction fetch and data access) and the shared port.

## Interface
- `N`, 16, width of each requester's data and of the shared output.
- `MAX_HOLD`, 8, maximum consecutive grant cycles while the other side is requesting (≥1).
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req0`  in  1  requester 0 wants the resource; held high for the whole transaction.
- `req1`  in  1  requester 1 wants the resource; held high for the whole transaction.
- `d0`  in  N  requester 0 data.
- `d1`  in  N  requester 1 data.
- `gnt0`  out  1  requester 0 owns the resource (registered).
- `gnt1`  out  1  requester 1 owns the resource (registered).
- `sel`  out  1  shared mux select; 1 = requester 1.
- `out`  out  N  shared datapath output: `sel ? d1 : d0` (combinational via internal `mux2 #(N)`).
- `out_valid`  out  1  `gnt0 | gnt1`.

Clock `clk`; reset is synchronous and active-low (`rst_n`).

## Operation
- Registered state: `state` ∈ {IDLE, GRANT0, GRANT1}, `last` (last granted requester), and `hold_cnt` of width `$clog2(MAX_HOLD)`, minimum 1 bit.
- Reset values (`rst_n`=0 at an edge): state IDLE, `gnt0`=`gnt1`=0, `sel`=0, `out_valid`=0, `hold_cnt`=0, `last`=1, so requester 0 wins the first tie.
- IDLE:
  - Only `req0` high → GRANT0; only `req1` high → GRANT1.
  - Both high → grant the requester ≠ `last`.
  - Neither high → stay in IDLE.
- GRANTx (x owns the resource; y is the other requester):
  - `reqx`=0 and `reqy`=1 → GRANTy directly, with no idle cycle.
  - `reqx`=0 and `reqy`=0 → IDLE.
  - `reqx`=1, `reqy`=1 and `hold_cnt`==`MAX_HOLD`-1 → GRANTy (preemption).
  - Otherwise stay in GRANTx; `hold_cnt` increments and saturates at `MAX_HOLD`-1.
- Every entry into a GRANT state clears `hold_cnt` to 0 and sets `last` to the new owner.
- Without contention an owner holds the resource indefinitely. The saturated counter forces preemption on the first cycle the other requester appears.
- Outputs:
  - `gnt0` = (state==GRANT0) and `gnt1` = (state==GRANT1); never both high.
  - `sel` = 1 in GRANT1 and 0 in GRANT0. In IDLE it holds its previous value, so the mux does not toggle needlessly.
- `MAX_HOLD`=1 gives strict cycle-by-cycle alternation under contention.

## Timing
- Grant latency: a request sampled high at edge k from IDLE gives a grant visible from edge k through k+1. Out of reset, the first grant is one cycle after the first sampled request.
- Release: `reqx` sampled low at edge k drops `gntx` after edge k. A handoff grant to y rises at the same edge, with zero dead cycles.
- Preemption: under continuous contention each owner holds exactly `MAX_HOLD` cycles.
- `out` follows `sel`, `d0` and `d1` combinationally with no added latency. `out` is meaningful only when `out_valid`=1.
- Requesters must not rely on a grant before it is visible. Dropping `req` mid-grant is always legal.
- Reset asserted mid-grant: at the next edge all outputs take their reset values regardless of `req`. Arbitration resumes from IDLE with `last`=1.

## Test plan
- Reset then idle: hold `rst_n`=0 for 2 cycles, then release with no requests → `gnt0`=`gnt1`=0, `sel`=0, `out_valid`=0 indefinitely.
- Single requester: assert `req1` at cycle 0, hold it 20 cycles, `d1`=16'hBEEF → `gnt1`=1 from cycle 1 for 20 cycles, `sel`=1, `out`=16'hBEEF. No preemption occurs, and the grant drops the cycle after `req1` falls.
- First tie out of reset: assert `req0` and `req1` at the same edge → `gnt0` first. With `MAX_HOLD`=8, `gnt0` is high for cycles 1–8 and `gnt1` for cycles 9–16, then `gnt0` again; `gnt0` and `gnt1` are never both high.
- Zero-gap handoff: `req0` is granted, `req1` rises, then `req0` drops at cycle 3 before the hold expires → `gnt1`=1 at cycle 4 and `hold_cnt` restarts at 0.
- `MAX_HOLD`=1 under contention: both requests held high → `gnt0` and `gnt1` alternate every cycle, and `sel` toggles each cycle.
- Reset mid-grant: `gnt1` active at cycle 5, `rst_n`=0 sampled at edge 5 → all outputs at reset values at cycle 6. After release with both requests high, `gnt0` wins.
